// File: rtl/rx_frame_packer.sv
// -----------------------------------------------------------------------------
// rx_frame_packer
//
// Pulls receive-FIFO words and assembles them into mono or stereo sample
// frames for a downstream consumer. In stereo mode the first word read is the
// left channel and the second is the right. In mono mode one word fills both
// channels. Samples are either 16-bit, taken from word bits [15:0] and
// sign-extended, or full 32-bit words.
//
// A completed frame is held on left/right with frame_valid high until the
// consumer accepts it (frame_valid & frame_ready). At most one FIFO read is
// ever outstanding, so fifo_ren can only be high in the two read states.
//
// Build option:
//   RX_FRAME_CNT_EN  defined   -> 16-bit wrapping count of accepted frames
//                    undefined -> frame_cnt tied to zero, no counter flops
//
// Ports:
//   rclk         in   read-side clock
//   rst_n        in   asynchronous active-low reset (release synchronised)
//   enable       in   start new frames; deasserting lets the current one finish
//   clear        in   synchronous abort back to IDLE, drops any held frame
//   stereo       in   1 = L/R word pair per frame, 0 = one word per frame
//   frame_size   in   0 = 16-bit sign-extended samples, 1 = 32-bit samples
//   fifo_dout    in   [31:0] FIFO read data, valid the cycle after fifo_ren
//   fifo_empty   in   FIFO empty flag
//   fifo_ren     out  FIFO read strobe
//   left         out  [31:0] left (or mono) sample
//   right        out  [31:0] right sample (copy of left in mono mode)
//   frame_valid  out  left/right hold a complete frame
//   frame_ready  in   consumer accepts the frame
//   frame_cnt    out  [15:0] accepted frame count
//
// State table:
//   state  | meaning
//   IDLE   | no frame in progress; waits for enable
//   RD_L   | issue left (or mono) read when FIFO is not empty
//   WT_L   | left data on fifo_dout; capture it
//   RD_R   | issue right read when FIFO is not empty
//   WT_R   | right data on fifo_dout; capture it
//   HOLD   | frame presented, waiting for the consumer
// -----------------------------------------------------------------------------
`default_nettype none

module rx_frame_packer (
    input  logic        rclk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clear,
    input  logic        stereo,
    input  logic        frame_size,
    input  logic [31:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_ren,
    output logic [31:0] left,
    output logic [31:0] right,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_L = 3'd1,
        S_WT_L = 3'd2,
        S_RD_R = 3'd3,
        S_WT_R = 3'd4,
        S_HOLD = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [1:0]  r_rst_sync;
    logic        w_run_ok;

    logic [31:0] r_left;
    logic [31:0] r_right;
    logic [31:0] w_sample;

    logic        w_ren;
    logic        w_valid;
    logic        w_cap_l;
    logic        w_cap_r;

    // Reset release is retimed through two flops so the FSM cannot leave
    // IDLE on the same edge that first sees rst_n high.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run_ok = r_rst_sync[1];

    // ---------------------------------------------------------------- state
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable && w_run_ok) begin
                        w_state_nxt = S_RD_L;
                    end
                end
                S_RD_L: begin
                    if (!fifo_empty) begin
                        w_state_nxt = S_WT_L;
                    end
                end
                S_WT_L: begin
                    w_state_nxt = stereo ? S_RD_R : S_HOLD;
                end
                S_RD_R: begin
                    if (!fifo_empty) begin
                        w_state_nxt = S_WT_R;
                    end
                end
                S_WT_R: begin
                    w_state_nxt = S_HOLD;
                end
                S_HOLD: begin
                    if (frame_ready) begin
                        w_state_nxt = enable ? S_RD_L : S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    // clear gates both the read strobe and the captures, so a word that
    // arrives while clear is high is simply dropped.
    always_comb begin
        w_ren   = 1'b0;
        w_valid = 1'b0;
        w_cap_l = 1'b0;
        w_cap_r = 1'b0;
        case (r_state)
            S_RD_L,
            S_RD_R: w_ren   = !fifo_empty && !clear;
            S_WT_L: w_cap_l = !clear;
            S_WT_R: w_cap_r = !clear;
            S_HOLD: w_valid = 1'b1;
            default: begin
            end
        endcase
    end

    assign fifo_ren    = w_ren;
    assign frame_valid = w_valid;

    // ------------------------------------------------------------ datapath
    assign w_sample = frame_size ? fifo_dout
                                 : {{16{fifo_dout[15]}}, fifo_dout[15:0]};

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_left  <= 32'h0;
            r_right <= 32'h0;
        end else begin
            if (w_cap_l) begin
                r_left <= w_sample;
                // Mono frames mirror the single sample onto the right channel.
                if (!stereo) begin
                    r_right <= w_sample;
                end
            end
            if (w_cap_r) begin
                r_right <= w_sample;
            end
        end
    end

    assign left  = r_left;
    assign right = r_right;

    // -------------------------------------------------------- frame counter
`ifdef RX_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
    logic        w_handshake;

    // clear wins over a simultaneous accept, so it is excluded here.
    assign w_handshake = w_valid && frame_ready && !clear;

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 16'h0;
        end else if (w_handshake) begin
            r_frame_cnt <= r_frame_cnt + 16'h1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = 16'h0;
`endif

endmodule

`default_nettype wire

// File: doc/rx_frame_packer.md
RX_FRAME_PACKER -- requirements
Module: rx_frame_packer

Interface
REQ-001 rclk  input  1  read-side clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous and active-low.
REQ-003 enable  input  1  1 = start new frame reads; 0 = stop after the frame in progress.
REQ-004 clear  input  1  synchronous abort; discards any partial or held frame.
REQ-005 stereo  input  1  1 = two FIFO words (L then R) per frame; 0 = one word per frame.
REQ-006 frame_size  input  1  0 = 16-bit samples in word bits [15:0]; 1 = 32-bit samples.
REQ-007 fifo_dout  input  32  receive FIFO read data, valid the cycle after a granted read.
REQ-008 fifo_empty  input  1  receive FIFO empty flag.
REQ-009 fifo_ren  output  1  receive FIFO read strobe.
REQ-010 left  output  32  left (or mono) sample, sign-extended.
REQ-011 right  output  32  right sample; equals left when stereo=0.
REQ-012 frame_valid  output  1  left/right hold a complete frame.
REQ-013 frame_ready  input  1  consumer accepts the frame.
REQ-014 frame_cnt  output  16  count of accepted frames.

Function
REQ-015 FSM states: IDLE, RD_L, WT_L, RD_R, WT_R, HOLD.
REQ-016 IDLE -> RD_L when enable=1; otherwise stay in IDLE.
REQ-017 RD_L / RD_R: fifo_ren = !fifo_empty (combinational). Advance to WT_L / WT_R only when fifo_empty=0; otherwise stay.
REQ-018 fifo_ren is 0 in every other state, so at most one read is outstanding.
REQ-019 WT_L: capture fifo_dout into left. Next state is RD_R if stereo=1, else HOLD with right <= same value as left.
REQ-020 WT_R: capture fifo_dout into right, then -> HOLD.
REQ-021 Capture format, frame_size=0: sample = fifo_dout[15:0] sign-extended from bit 15; bits [31:16] of fifo_dout are ignored.
REQ-022 Capture format, frame_size=1: sample = fifo_dout unchanged.
REQ-023 stereo and frame_size are sampled at each capture edge; software changes them only while in IDLE.
REQ-024 HOLD: frame_valid=1. left and right are stable until handshake.
REQ-025 Handshake = frame_valid & frame_ready. On handshake -> RD_L if enable=1, else IDLE.
REQ-026 frame_valid goes low the cycle after the handshake.
REQ-027 enable=0 while in RD_L..WT_R does not abort the frame; the pair completes and is presented.
REQ-028 clear=1 in any state -> IDLE next cycle; frame_valid=0; left/right unchanged.
REQ-029 A word returned during clear is dropped. fifo_ren=0 while clear=1.
REQ-030 clear has priority over handshake and enable.
REQ-031 frame_cnt increments by 1 on each handshake and wraps 0xFFFF -> 0x0000.
REQ-032 clear does not reset frame_cnt.
REQ-033 Latency: non-empty FIFO entering RD_L -> frame_valid 2 cycles later (mono) or 4 cycles later (stereo).

Reset
REQ-034 rst_n=0 immediately forces: state IDLE, fifo_ren=0, frame_valid=0, left=0, right=0, frame_cnt=0.
REQ-035 Reset deassertion is synchronised to rclk; the first transition out of IDLE occurs no earlier than the second rclk edge after release.
REQ-036 Reset mid-read discards the outstanding word; no FIFO pointer restore is attempted.

Configuration
REQ-037 Macro RX_FRAME_CNT_EN defined: frame_cnt implemented per REQ-031/REQ-032.
REQ-038 Macro RX_FRAME_CNT_EN undefined: frame_cnt tied to 0, no counter flops; all other behaviour identical.

Verification
REQ-039 Stereo, frame_size=1: FIFO words 0x11112222, 0x33334444, frame_ready=1 -> left=0x11112222, right=0x33334444, frame_valid 4 cycles after RD_L entry, frame_cnt=1.
REQ-040 Mono, frame_size=0: word 0x0000_8001 -> left=right=0xFFFF8001. Word 0xABCD_7FFF -> left=right=0x00007FFF.
REQ-041 fifo_empty=1 held 10 cycles in RD_R -> fifo_ren=0 throughout, left held. Then empty=0 -> single ren pulse, frame completes.
REQ-042 frame_ready=0 for 20 cycles in HOLD -> frame_valid=1 and outputs stable, no fifo_ren. frame_ready=1 -> frame_valid low next cycle.
REQ-043 clear asserted in WT_L -> next cycle IDLE, frame_valid=0; the following stereo pair is captured with L/R order intact.
REQ-044 65536 accepted frames with RX_FRAME_CNT_EN -> frame_cnt=0x0000. Same run without the macro -> frame_cnt=0 throughout. rst_n pulse mid-frame -> all outputs 0 immediately.
